// File: rtl/input_debouncer.sv
// Multi-channel switch debouncer: 2-flop synchronizer, shared sample tick, per-channel stability count.
// Define DEBOUNCE_EDGE_DETECT_EN to build the rise/fall pulse registers; otherwise the pulse ports are tied 0.
module input_debouncer #(
  parameter int DATA_WIDTH   = 16,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] raw_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [DATA_WIDTH-1:0] rise_pulse,
  output logic [DATA_WIDTH-1:0] fall_pulse
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);

  logic [DATA_WIDTH-1:0]         sync1;
  logic [DATA_WIDTH-1:0]         sync2;
  logic [TW-1:0]                 tick_cnt;
  logic                          tick;
  logic [DATA_WIDTH-1:0][CW-1:0] stab_cnt;
  logic [DATA_WIDTH-1:0][CW-1:0] stab_cnt_nxt;
  logic [DATA_WIDTH-1:0]         accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // Any matching tick wipes progress, so a level must mismatch on
  // STABLE_TICKS consecutive ticks before it is accepted.
  always_comb begin
    stab_cnt_nxt = stab_cnt;
    accept       = '0;
    if (tick) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (sync2[i] == data_out[i]) begin
          stab_cnt_nxt[i] = '0;
        end else if (stab_cnt[i] == CNT_LAST) begin
          stab_cnt_nxt[i] = '0;
          accept[i]       = 1'b1;
        end else begin
          stab_cnt_nxt[i] = stab_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stab_cnt <= '0;
      data_out <= '0;
    end else begin
      stab_cnt <= stab_cnt_nxt;
      data_out <= (data_out & ~accept) | (sync2 & accept);
    end
  end

`ifdef DEBOUNCE_EDGE_DETECT_EN
  // Registered alongside data_out so each pulse lines up with the first cycle of the new level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rise_pulse <= '0;
      fall_pulse <= '0;
    end else begin
      rise_pulse <= accept & sync2;
      fall_pulse <= accept & ~sync2;
    end
  end
`else
  assign rise_pulse = '0;
  assign fall_pulse = '0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer (TICK_DIV=4, STABLE_TICKS=3, 16 channels).
module tb_input_debouncer;

  localparam int DW = 16;
  localparam int TD = 4;
  localparam int ST = 3;
`ifdef DEBOUNCE_EDGE_DETECT_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] raw_in = '0;
  logic [DW-1:0] data_out;
  logic [DW-1:0] rise_pulse;
  logic [DW-1:0] fall_pulse;

  input_debouncer #(.DATA_WIDTH(DW), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .clk        (clk),
    .reset      (reset),
    .raw_in     (raw_in),
    .data_out   (data_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: the value the debouncer sees is the raw level from two
  // edges earlier; every TD-th edge after reset is a sample point; a channel
  // flips after ST consecutive sample points that disagree with its output.
  logic [DW-1:0] pipe_q[$];
  logic [DW-1:0] m_data;
  logic [DW-1:0] m_rise;
  logic [DW-1:0] m_fall;
  int            streak[DW];
  int            edge_k;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int val, input int lo, input int hi);
    tests++;
    if (val < lo || val > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
    end
  endtask

  task automatic model_reset();
    pipe_q = '{16'h0, 16'h0};
    m_data = '0;
    m_rise = '0;
    m_fall = '0;
    edge_k = 0;
    for (int i = 0; i < DW; i++) streak[i] = 0;
  endtask

  task automatic model_edge(input logic [DW-1:0] raw);
    logic [DW-1:0] seen;
    seen = pipe_q.pop_front();
    pipe_q.push_back(raw);
    edge_k++;
    m_rise = '0;
    m_fall = '0;
    if (edge_k % TD == 0) begin
      for (int i = 0; i < DW; i++) begin
        if (seen[i] != m_data[i]) begin
          streak[i]++;
          if (streak[i] == ST) begin
            m_data[i] = seen[i];
            streak[i] = 0;
            if (seen[i]) m_rise[i] = EDGE_EN;
            else         m_fall[i] = EDGE_EN;
          end
        end else begin
          streak[i] = 0;
        end
      end
    end
  endtask

  task automatic step(input logic [DW-1:0] raw);
    raw_in = raw;
    @(posedge clk);
    #1;
    model_edge(raw);
    check("data_out", data_out, m_data);
    check("rise_pulse", rise_pulse, m_rise);
    check("fall_pulse", fall_pulse, m_fall);
    check("pulse_excl", rise_pulse & fall_pulse, 16'h0);
  endtask

  task automatic do_reset(input logic [DW-1:0] raw, input int ncyc);
    raw_in = raw;
    reset  = 1'b0;
    #1;
    check("rst_data", data_out, 16'h0);
    check("rst_rise", rise_pulse, 16'h0);
    check("rst_fall", fall_pulse, 16'h0);
    model_reset();
    repeat (ncyc) @(posedge clk);
    #1;
    check("rst_hold_data", data_out, 16'h0);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [DW-1:0] raw;
    int            hold;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs[6];
  int   n;
  bit   found;
  bit   bad;

  initial begin
    vecs[0] = '{raw: 16'h0001, hold: 20, exp_data: 16'h0001};
    vecs[1] = '{raw: 16'h0009, hold: 5,  exp_data: 16'h0001};
    vecs[2] = '{raw: 16'h0001, hold: 20, exp_data: 16'h0001};
    vecs[3] = '{raw: 16'h00F0, hold: 20, exp_data: 16'h00F0};
    vecs[4] = '{raw: 16'hFFFF, hold: 20, exp_data: 16'hFFFF};
    vecs[5] = '{raw: 16'h0000, hold: 20, exp_data: 16'h0000};

    do_reset(16'h0, 3);
    for (int v = 0; v < 6; v++) begin
      repeat (vecs[v].hold) step(vecs[v].raw);
      check($sformatf("vec%0d_data", v), data_out, vecs[v].exp_data);
    end

    // Single rising channel: latency window and pulse alignment.
    do_reset(16'h0, 2);
    repeat (6) step(16'h0);
    n = 0; found = 0;
    for (int c = 1; c <= 20 && !found; c++) begin
      step(16'h0001);
      if (data_out[0]) begin found = 1; n = c; end
    end
    check_range("rise_latency", found ? n : -1, 11, 14);
    check("rise_data", data_out, 16'h0001);
    check("rise_pulse0", rise_pulse, EDGE_EN ? 16'h0001 : 16'h0);
    check("rise_fall0", fall_pulse, 16'h0);
    step(16'h0001);
    check("rise_pulse_next", rise_pulse, 16'h0);

    // Short glitch on channel 3.
    do_reset(16'h0, 2);
    bad = 0;
    repeat (5) begin step(16'h0008); if (data_out[3] || rise_pulse || fall_pulse) bad = 1; end
    repeat (25) begin step(16'h0000); if (data_out[3] || rise_pulse || fall_pulse) bad = 1; end
    check("glitch3", {15'h0, bad}, 16'h0);

    // All ones held through reset release.
    do_reset(16'hFFFF, 2);
    n = 0; found = 0; bad = 0;
    for (int c = 1; c <= 20 && !found; c++) begin
      step(16'hFFFF);
      if (data_out != 16'h0 && data_out != 16'hFFFF) bad = 1;
      if (data_out == 16'hFFFF) begin found = 1; n = c; end
    end
    check("all_together", {15'h0, bad}, 16'h0);
    check_range("all_latency", found ? n : -1, 1, 14);
    check("all_rise", rise_pulse, EDGE_EN ? 16'hFFFF : 16'h0);

    // Channel 5 toggling every 3 cycles never settles long enough.
    do_reset(16'h0, 2);
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      step(((c / 3) % 2) != 0 ? 16'h0020 : 16'h0000);
      if (data_out[5]) bad = 1;
    end
    repeat (20) begin step(16'h0); if (data_out[5]) bad = 1; end
    check("toggle5", {15'h0, bad}, 16'h0);

    // Reset mid-count discards progress.
    do_reset(16'h0, 2);
    repeat (3) step(16'h0);
    repeat (6) step(16'h0004);
    do_reset(16'h0004, 2);
    n = 0; found = 0;
    for (int c = 1; c <= 20 && !found; c++) begin
      step(16'h0004);
      if (data_out[2]) begin found = 1; n = c; end
    end
    check_range("rst_mid_latency", found ? n : -1, 11, 14);

    // Randomized levels with occasional single-cycle glitches.
    begin
      logic [DW-1:0] target;
      logic [DW-1:0] noise;
      do_reset(16'h0, 2);
      target = '0;
      for (int c = 0; c < 600; c++) begin
        for (int i = 0; i < DW; i++)
          if ($urandom_range(0, 15) == 0) target[i] = ~target[i];
        noise = ($urandom_range(0, 7) == 0) ? DW'($urandom) : '0;
        step(target ^ noise);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
